// File: rtl/keypad_pkg.sv
// Shared types for the keypad event capture block: FSM states, frame classes and key code width.
package keypad_pkg;

    localparam int unsigned KEY_CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        KEY   = 2'd1,
        MULTI = 2'd2
    } frame_class_t;

    // Collapse the accumulated frame flags into a single frame class.
    function automatic frame_class_t classify(input logic hit, input logic multi);
        frame_class_t cls;
        cls = EMPTY;
        if (hit) begin
            cls = multi ? MULTI : KEY;
        end
        return cls;
    endfunction

endpackage

// File: rtl/keypad_frame_accum.sv
// Folds the per-column press/data stream into one observation per 4-cycle scan frame.
module keypad_frame_accum
    import keypad_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_start,
    input  logic                  press,
    input  logic [KEY_CODE_W-1:0] data,
    output logic                  o_frame_done_c,
    output logic [1:0]            o_frame_class_c,
    output logic [KEY_CODE_W-1:0] o_frame_code_c
);

    logic                  r_first;
    logic                  r_hit;
    logic                  r_multi;
    logic [KEY_CODE_W-1:0] r_code;
    frame_class_t          w_class;

    // Reload on the frame marker, otherwise merge; the frame in flight at reset is partial.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_first <= 1'b1;
            r_hit   <= 1'b0;
            r_multi <= 1'b0;
            r_code  <= '0;
        end else if (scan_start) begin
            r_first <= 1'b0;
            r_hit   <= press;
            r_multi <= 1'b0;
            r_code  <= press ? data : '0;
        end else if (press) begin
            if (!r_hit) begin
                r_hit  <= 1'b1;
                r_code <= data;
            end else if (data != r_code) begin
                r_multi <= 1'b1;
            end
        end
    end

    always_comb begin
        w_class = classify(r_hit, r_multi);
    end

    assign o_frame_done_c  = rst_n & scan_start & ~r_first;
    assign o_frame_class_c = w_class;
    assign o_frame_code_c  = r_code;

endmodule

// File: rtl/keypad_event_capture.sv
// Frame-level debounce/release FSM that latches one key code per physical press
// and raises a pending interrupt for the CPU, cleared by an acknowledge strobe.
module keypad_event_capture
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned RELEASE_FRAMES  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_start,
    input  logic                  press,
    input  logic [KEY_CODE_W-1:0] data,
    input  logic                  ack,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_int,
    output logic                  overrun
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_FRAMES > RELEASE_FRAMES) ? DEBOUNCE_FRAMES
                                                                         : RELEASE_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] REL_LIM = CNT_W'(RELEASE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                  w_frame_done;
    logic [1:0]            w_frame_class;
    logic [KEY_CODE_W-1:0] w_frame_code;
    frame_class_t          w_class;

    state_t                r_state;
    logic [KEY_CODE_W-1:0] r_cand;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_rcnt;
    logic [KEY_CODE_W-1:0] r_key_code;
    logic                  r_key_valid;
    logic                  r_key_int;
    logic                  r_overrun;

    state_t                w_state_nxt;
    logic [KEY_CODE_W-1:0] w_cand_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CNT_W-1:0]      w_rcnt_nxt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [CNT_W-1:0]      w_rcnt_inc;
    logic                  w_accept;
    logic [KEY_CODE_W-1:0] w_key_code_nxt;
    logic                  w_key_int_nxt;
    logic                  w_overrun_nxt;

    keypad_frame_accum u_accum (
        .clk             (clk),
        .rst_n           (rst_n),
        .scan_start      (scan_start),
        .press           (press),
        .data            (data),
        .o_frame_done_c  (w_frame_done),
        .o_frame_class_c (w_frame_class),
        .o_frame_code_c  (w_frame_code)
    );

    assign w_class    = frame_class_t'(w_frame_class);
    assign w_cnt_inc  = (&r_cnt)  ? r_cnt  : r_cnt  + CNT_ONE;
    assign w_rcnt_inc = (&r_rcnt) ? r_rcnt : r_rcnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cand      <= '0;
            r_cnt       <= '0;
            r_rcnt      <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_int   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rcnt      <= w_rcnt_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_accept;
            r_key_int   <= w_key_int_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // Next state advances only when a frame closes; everything holds otherwise.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_rcnt_nxt  = r_rcnt;
        w_accept    = 1'b0;

        if (w_frame_done) begin
            unique case (r_state)
                IDLE: begin
                    if (w_class == KEY) begin
                        w_cand_nxt  = w_frame_code;
                        w_cnt_nxt   = CNT_ONE;
                        w_state_nxt = CONFIRM;
                        w_accept    = (CNT_ONE >= DEB_LIM);
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                CONFIRM: begin
                    if (w_class == KEY && w_frame_code == r_cand) begin
                        w_cnt_nxt = w_cnt_inc;
                        w_accept  = (w_cnt_inc >= DEB_LIM);
                    end else if (w_class == KEY) begin
                        w_cand_nxt = w_frame_code;
                        w_cnt_nxt  = CNT_ONE;
                        w_accept   = (CNT_ONE >= DEB_LIM);
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                HELD: begin
                    if (w_class == EMPTY) begin
                        if (CNT_ONE >= REL_LIM) begin
                            w_state_nxt = IDLE;
                            w_rcnt_nxt  = '0;
                        end else begin
                            w_state_nxt = RELEASE;
                            w_rcnt_nxt  = CNT_ONE;
                        end
                    end else begin
                        w_rcnt_nxt = '0;
                    end
                end
                RELEASE: begin
                    if (w_class == EMPTY) begin
                        if (w_rcnt_inc >= REL_LIM) begin
                            w_state_nxt = IDLE;
                            w_rcnt_nxt  = '0;
                        end else begin
                            w_rcnt_nxt = w_rcnt_inc;
                        end
                    end else begin
                        w_state_nxt = HELD;
                        w_rcnt_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        if (w_accept) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
            w_rcnt_nxt  = '0;
        end

        // An accept in the same cycle as ack keeps the interrupt pending without flagging overrun.
        w_key_code_nxt = w_accept ? w_cand_nxt : r_key_code;
        w_key_int_nxt  = w_accept | (r_key_int & ~ack);
        w_overrun_nxt  = ~ack & (r_overrun | (w_accept & r_key_int));
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_int   = r_key_int;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_event_capture.sv
// Directed and randomized frames checked every cycle against a frame-history reference model.
module tb_keypad_event_capture;

    localparam int DEB = 4;
    localparam int REL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_start;
    logic       press;
    logic [3:0] data;
    logic       ack;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_int;
    logic       overrun;

    always #5 clk = ~clk;

    keypad_event_capture #(
        .DEBOUNCE_FRAMES (DEB),
        .RELEASE_FRAMES  (REL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_start (scan_start),
        .press      (press),
        .data       (data),
        .ack        (ack),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_int    (key_int),
        .overrun    (overrun)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_pulses = 0;

    // Reference model: frames are kept as a short history of classes
    // (-1 empty, -2 multiple keys, 0..15 single key code).
    bit         m_discard;
    bit         m_armed;
    int         m_empty_run;
    int         m_hist[$];
    bit         samp_p[$];
    int         samp_d[$];
    logic [3:0] m_code;
    logic       m_valid;
    logic       m_int;
    logic       m_ovr;

    function automatic int close_frame();
        int first = -1;
        bit multi = 1'b0;
        for (int i = 0; i < samp_p.size(); i++) begin
            if (samp_p[i]) begin
                if (first < 0) first = samp_d[i];
                else if (samp_d[i] != first) multi = 1'b1;
            end
        end
        if (first < 0) return -1;
        return multi ? -2 : first;
    endfunction

    task automatic model_step(input logic rn, input logic ss, input logic p,
                              input logic [3:0] d, input logic a);
        bit acc = 1'b0;
        bit same;
        int cls;
        if (!rn) begin
            m_discard = 1'b1;
            m_armed = 1'b1;
            m_empty_run = 0;
            m_hist.delete();
            samp_p.delete();
            samp_d.delete();
            m_code = 4'd0;
            m_valid = 1'b0;
            m_int = 1'b0;
            m_ovr = 1'b0;
            return;
        end
        if (ss) begin
            if (!m_discard) begin
                cls = close_frame();
                m_hist.push_back(cls);
                if (m_hist.size() > DEB) void'(m_hist.pop_front());
                if (cls == -1) begin
                    m_empty_run++;
                    if (m_empty_run >= REL) m_armed = 1'b1;
                end else begin
                    m_empty_run = 0;
                end
                // Accept: armed by a full release and the last DEB frames all show this one key.
                if (m_armed && cls >= 0 && m_hist.size() == DEB) begin
                    same = 1'b1;
                    foreach (m_hist[i]) if (m_hist[i] != cls) same = 1'b0;
                    acc = same;
                end
                if (acc) begin
                    m_armed = 1'b0;
                    m_empty_run = 0;
                    m_code = 4'(cls);
                end
            end
            m_discard = 1'b0;
            samp_p.delete();
            samp_d.delete();
        end
        samp_p.push_back(p);
        samp_d.push_back(int'(d));
        m_ovr   = !a && (m_ovr || (acc && m_int));
        m_int   = acc || (m_int && !a);
        m_valid = acc;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rn, input logic ss, input logic p,
                       input logic [3:0] d, input logic a);
        rst_n = rn; scan_start = ss; press = p; data = d; ack = a;
        @(posedge clk);
        model_step(rn, ss, p, d, a);
        #1;
        chk("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
        chk("key_int",   {3'b0, key_int},   {3'b0, m_int});
        chk("overrun",   {3'b0, overrun},   {3'b0, m_ovr});
        chk("key_code",  key_code,          m_code);
        if (key_valid === 1'b1) n_pulses++;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        n_pulses = 0;
    endtask

    // One 4-cycle frame; non-pressed columns carry junk data that must be ignored.
    task automatic frame(input logic [3:0] pm, input logic [15:0] codes, input logic [3:0] am);
        for (int k = 0; k < 4; k++)
            cyc(1'b1, k == 0, pm[k], pm[k] ? codes[4*k +: 4] : 4'($urandom), am[k]);
    endtask

    task automatic key_f(input logic [3:0] c, input logic [3:0] am = 4'b0);
        logic [3:0] pm;
        pm = 4'b0001 << $urandom_range(0, 3);
        frame(pm, {c, c, c, c}, am);
    endtask

    task automatic empty_f(input logic [3:0] am = 4'b0);
        frame(4'b0000, 16'h0, am);
    endtask

    task automatic multi_f(input logic [3:0] c1, input logic [3:0] c2);
        frame(4'b0101, {4'h0, c2, 4'h0, c1}, 4'b0);
    endtask

    task automatic rand_frame(input int kind, input logic [3:0] c);
        logic [3:0] pm;
        logic [3:0] d;
        pm = (kind == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        if (kind == 2) pm = pm | 4'b1001;
        for (int k = 0; k < 4; k++) begin
            d = pm[k] ? c : 4'($urandom);
            if (kind == 2 && k == 3) d = c ^ 4'($urandom_range(1, 15));
            cyc(1'b1, k == 0, pm[k], d, $urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        int len;
        int mode;
        logic [3:0] c;

        // Reset values
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        do_reset();
        chk("rst_key_code",  key_code, 4'd0);
        chk("rst_key_valid", {3'b0, key_valid}, 4'd0);
        chk("rst_key_int",   {3'b0, key_int},   4'd0);
        chk("rst_overrun",   {3'b0, overrun},   4'd0);

        // Key 5 held 6 frames: exactly one accept
        for (int i = 0; i < 6; i++) key_f(4'd5);
        empty_f();
        chk("t1_pulses", 4'(n_pulses), 4'd1);
        chk("t1_code", key_code, 4'd5);
        chk("t1_int", {3'b0, key_int}, 4'd1);
        chk("t1_ovr", {3'b0, overrun}, 4'd0);

        // Key 7 with a bounce: K E K K K K
        do_reset();
        key_f(4'd7); empty_f();
        for (int i = 0; i < 3; i++) key_f(4'd7);
        key_f(4'd7);
        chk("t2_no_early", 4'(n_pulses), 4'd0);
        empty_f();
        chk("t2_pulses", 4'(n_pulses), 4'd1);
        chk("t2_code", key_code, 4'd7);

        // Overrun: key 2 unacked, full release, key 9
        do_reset();
        for (int i = 0; i < 4; i++) key_f(4'd2);
        for (int i = 0; i < 5; i++) empty_f();
        for (int i = 0; i < 4; i++) key_f(4'd9);
        empty_f();
        chk("t3_code", key_code, 4'd9);
        chk("t3_ovr", {3'b0, overrun}, 4'd1);
        chk("t3_int", {3'b0, key_int}, 4'd1);
        empty_f(4'b0010);
        chk("t3_ack_int", {3'b0, key_int}, 4'd0);
        chk("t3_ack_ovr", {3'b0, overrun}, 4'd0);

        // Ack while held, short release, then full release
        do_reset();
        for (int i = 0; i < 5; i++) key_f(4'd3);
        key_f(4'd3, 4'b0100);
        for (int i = 0; i < 3; i++) key_f(4'd3);
        chk("t4_int_cleared", {3'b0, key_int}, 4'd0);
        for (int i = 0; i < 3; i++) empty_f();
        for (int i = 0; i < 5; i++) key_f(4'd3);
        chk("t4_short_release", 4'(n_pulses), 4'd1);
        for (int i = 0; i < 4; i++) empty_f();
        for (int i = 0; i < 4; i++) key_f(4'd3);
        empty_f();
        chk("t4_second_accept", 4'(n_pulses), 4'd2);

        // MULTI in CONFIRM aborts; MULTI in HELD holds
        do_reset();
        key_f(4'd6); key_f(4'd6); multi_f(4'd6, 4'd8);
        for (int i = 0; i < 3; i++) key_f(4'd6);
        key_f(4'd6);
        chk("t5_multi_abort", 4'(n_pulses), 4'd0);
        empty_f();
        chk("t5_accept", 4'(n_pulses), 4'd1);
        multi_f(4'd1, 4'd2); multi_f(4'd3, 4'd4);
        for (int i = 0; i < 3; i++) empty_f();
        for (int i = 0; i < 5; i++) key_f(4'd6);
        chk("t5_held_multi", 4'(n_pulses), 4'd1);

        // Reset mid-debounce with an interrupt pending
        do_reset();
        for (int i = 0; i < 4; i++) key_f(4'd1);
        for (int i = 0; i < 5; i++) empty_f();
        for (int i = 0; i < 3; i++) key_f(4'd10);
        cyc(1'b1, 1'b1, 1'b1, 4'd10, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'd10, 1'b0);
        n_pulses = 0;
        chk("t6_rst_code", key_code, 4'd0);
        chk("t6_rst_int", {3'b0, key_int}, 4'd0);
        chk("t6_rst_ovr", {3'b0, overrun}, 4'd0);
        cyc(1'b1, 1'b0, 1'b1, 4'd10, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 4'd10, 1'b0);
        for (int i = 0; i < 3; i++) key_f(4'd10);
        key_f(4'd10);
        chk("t6_discard", 4'(n_pulses), 4'd0);
        empty_f();
        chk("t6_accept", 4'(n_pulses), 4'd1);
        chk("t6_code", key_code, 4'd10);

        // Accept coinciding with ack while a key is pending
        do_reset();
        for (int i = 0; i < 4; i++) key_f(4'd4);
        for (int i = 0; i < 5; i++) empty_f();
        for (int i = 0; i < 4; i++) key_f(4'd11);
        empty_f(4'b0001);
        chk("t7_int", {3'b0, key_int}, 4'd1);
        chk("t7_ovr", {3'b0, overrun}, 4'd0);
        chk("t7_code", key_code, 4'd11);

        // Lost frame marker: state holds
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t8_hold_int", {3'b0, key_int}, 4'd1);

        // Randomized traffic
        do_reset();
        for (int f = 0; f < 300; f++) begin
            mode = $urandom_range(0, 11);
            c = 4'($urandom_range(0, 5));
            if (mode <= 5) begin
                len = $urandom_range(1, 7);
                for (int i = 0; i < len; i++) rand_frame(1, c);
            end else if (mode <= 8) begin
                len = $urandom_range(1, 6);
                for (int i = 0; i < len; i++) rand_frame(0, c);
            end else if (mode == 9) begin
                rand_frame(2, c);
            end else if (mode == 10) begin
                len = $urandom_range(1, 6);
                for (int i = 0; i < len; i++)
                    cyc(1'b1, 1'b0, 1'($urandom), 4'($urandom), 1'b0);
            end else if ($urandom_range(0, 7) == 0) begin
                cyc(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
